// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit (forwarding, load-use stall, memory hold, timeout).
module hazard_ctrl (
    input  logic        clk,
    input  logic        clr,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic [4:0]  id_rn,
    input  logic        id_wreg,
    input  logic        id_m2reg,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        pipe_we,
    output logic        id_exe_bubble,
    output logic [1:0]  fwda,
    output logic [1:0]  fwdb,
    output logic [15:0] stall_cnt,
    output logic [15:0] hold_cnt,
    output logic        err,
    output logic [1:0]  state
);
    typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, HOLD = 2'b10} state_t;
    logic [4:0]  exe_rn_q, exe_rn_d, mem_rn_q, mem_rn_d;
    logic        exe_wreg_q, exe_wreg_d, exe_m2reg_q, exe_m2reg_d;
    logic        mem_wreg_q, mem_wreg_d, mem_m2reg_q, mem_m2reg_d;
    logic [15:0] stall_cnt_q, stall_cnt_d, hold_cnt_q, hold_cnt_d;
    logic [4:0]  consec_q, consec_d;
    logic        err_q, err_d;
    state_t      state_q, state_d;
    logic        hazard, hold, stall;

    // Nearest producer wins; register 0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] r,
        input logic [4:0] e_rn, input logic e_wr, input logic e_ld,
        input logic [4:0] m_rn, input logic m_wr, input logic m_ld
    );
        return (r == 5'd0) ? 2'b00 :
               (e_wr && !e_ld && e_rn == r) ? 2'b01 :
               (m_wr && m_rn == r) ? {1'b1, m_ld} : 2'b00;
    endfunction

    // A load in EXE cannot supply data to an ID reader this cycle.
    assign hazard = id_valid && exe_wreg_q && exe_m2reg_q && exe_rn_q != 5'd0 &&
                    ((id_use_rs && id_rs == exe_rn_q) || (id_use_rt && id_rt == exe_rn_q));
    // Reset forces the empty-pipe view; a stalled memory outranks load-use.
    assign hold  = !clr && !mem_ready;
    assign stall = !clr && mem_ready && hazard;

    assign pc_we         = !hold && !stall;
    assign if_id_we      = !hold && !stall;
    assign pipe_we       = !hold;
    assign id_exe_bubble = stall;
    assign fwda = fwd_sel(id_rs, exe_rn_q, exe_wreg_q, exe_m2reg_q, mem_rn_q, mem_wreg_q, mem_m2reg_q);
    assign fwdb = fwd_sel(id_rt, exe_rn_q, exe_wreg_q, exe_m2reg_q, mem_rn_q, mem_wreg_q, mem_m2reg_q);
    assign stall_cnt = stall_cnt_q;
    assign hold_cnt  = hold_cnt_q;
    assign err       = err_q;
    assign state     = state_q;

    // Next shadow, counters and recorded action for the coming edge.
    always_comb begin
        exe_rn_d    = hold ? exe_rn_q : stall ? 5'd0 : id_rn;
        exe_wreg_d  = hold ? exe_wreg_q : stall ? 1'b0 : id_wreg && id_valid;
        exe_m2reg_d = hold ? exe_m2reg_q : stall ? 1'b0 : id_m2reg && id_valid;
        mem_rn_d    = hold ? mem_rn_q : exe_rn_q;
        mem_wreg_d  = hold ? mem_wreg_q : exe_wreg_q;
        mem_m2reg_d = hold ? mem_m2reg_q : exe_m2reg_q;
        stall_cnt_d = stall_cnt_q + {15'd0, stall && stall_cnt_q != 16'hFFFF};
        hold_cnt_d  = hold_cnt_q + {15'd0, hold && hold_cnt_q != 16'hFFFF};
        consec_d    = hold ? consec_q + {4'd0, !consec_q[4]} : 5'd0;
        err_d       = err_q || consec_d[4];
        state_d     = hold ? HOLD : stall ? STALL : RUN;
    end

    // State update; clr wipes any in-flight hold or stall immediately.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            exe_rn_q    <= 5'd0;
            exe_wreg_q  <= 1'b0;
            exe_m2reg_q <= 1'b0;
            mem_rn_q    <= 5'd0;
            mem_wreg_q  <= 1'b0;
            mem_m2reg_q <= 1'b0;
            stall_cnt_q <= 16'd0;
            hold_cnt_q  <= 16'd0;
            consec_q    <= 5'd0;
            err_q       <= 1'b0;
            state_q     <= RUN;
        end else begin
            exe_rn_q    <= exe_rn_d;
            exe_wreg_q  <= exe_wreg_d;
            exe_m2reg_q <= exe_m2reg_d;
            mem_rn_q    <= mem_rn_d;
            mem_wreg_q  <= mem_wreg_d;
            mem_m2reg_q <= mem_m2reg_d;
            stall_cnt_q <= stall_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            consec_q    <= consec_d;
            err_q       <= err_d;
            state_q     <= state_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl with directed and random stimulus.
module tb_hazard_ctrl;
    logic clk = 0, clr = 1, id_valid = 0, id_use_rs = 0, id_use_rt = 0;
    logic id_wreg = 0, id_m2reg = 0, mem_ready = 1;
    logic [4:0] id_rs = 0, id_rt = 0, id_rn = 0;
    logic pc_we, if_id_we, pipe_we, id_exe_bubble, err;
    logic [1:0] fwda, fwdb, state;
    logic [15:0] stall_cnt, hold_cnt;
    int checks = 0, errors = 0;

    hazard_ctrl dut (
        .clk(clk), .clr(clr), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rn(id_rn), .id_wreg(id_wreg),
        .id_m2reg(id_m2reg), .mem_ready(mem_ready), .pc_we(pc_we), .if_id_we(if_id_we),
        .pipe_we(pipe_we), .id_exe_bubble(id_exe_bubble), .fwda(fwda), .fwdb(fwdb),
        .stall_cnt(stall_cnt), .hold_cnt(hold_cnt), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {logic [4:0] rn; logic wr; logic ld;} ent_t;
    typedef struct {logic clr, valid, urs, urt, wreg, ld, rdy; logic [4:0] rs, rt, rn;} in_t;
    typedef struct {logic pc, ifid, pipe, bub, er; logic [1:0] fa, fb, st; logic [15:0] sc, hc;} exp_t;

    exp_t sb[$];
    ent_t ex, mm;
    int m_stall, m_hold, m_consec;
    logic m_err;
    logic [1:0] m_state;
    in_t cur;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic [4:0] rn,
                               input logic wr, input logic ld, input logic rdy, input logic c);
        in_t s;
        s.valid = v; s.rs = rs; s.rt = rt; s.urs = urs; s.urt = urt; s.rn = rn;
        s.wreg = wr; s.ld = ld; s.rdy = rdy; s.clr = c;
        return s;
    endfunction

    function automatic logic [1:0] fsel(input logic [4:0] r);
        if (r == 0) return 2'd0;
        if (ex.wr && !ex.ld && ex.rn == r) return 2'd1;
        if (mm.wr && mm.rn == r) return mm.ld ? 2'd3 : 2'd2;
        return 2'd0;
    endfunction

    function automatic logic lu(input in_t s);
        return s.valid && ex.wr && ex.ld && ex.rn != 0 &&
               ((s.urs && s.rs == ex.rn) || (s.urt && s.rt == ex.rn));
    endfunction

    task automatic model_reset();
        ex = '{rn: 5'd0, wr: 1'b0, ld: 1'b0};
        mm = ex;
        m_stall = 0; m_hold = 0; m_consec = 0; m_err = 0; m_state = 2'd0;
    endtask

    // Apply one clock edge to the pipe model using the inputs that were presented.
    task automatic model_edge();
        if (cur.clr) model_reset();
        else if (!cur.rdy) begin
            if (m_hold < 65535) m_hold++;
            if (m_consec < 31) m_consec++;
            if (m_consec >= 16) m_err = 1;
            m_state = 2'd2;
        end else if (lu(cur)) begin
            mm = ex;
            ex = '{rn: 5'd0, wr: 1'b0, ld: 1'b0};
            if (m_stall < 65535) m_stall++;
            m_consec = 0;
            m_state = 2'd1;
        end else begin
            mm = ex;
            ex = '{rn: cur.rn, wr: cur.wreg && cur.valid, ld: cur.ld && cur.valid};
            m_consec = 0;
            m_state = 2'd0;
        end
    endtask

    task automatic step(input in_t s);
        exp_t e;
        logic h, st;
        @(posedge clk);
        model_edge();
        #1;
        cur = s;
        clr = s.clr; id_valid = s.valid; id_rs = s.rs; id_rt = s.rt; id_use_rs = s.urs;
        id_use_rt = s.urt; id_rn = s.rn; id_wreg = s.wreg; id_m2reg = s.ld; mem_ready = s.rdy;
        if (s.clr) model_reset();
        h  = !s.clr && !s.rdy;
        st = !s.clr && s.rdy && lu(s);
        e.pc = !h && !st; e.ifid = !h && !st; e.pipe = !h; e.bub = st;
        e.fa = fsel(s.rs); e.fb = fsel(s.rt); e.st = m_state;
        e.sc = 16'(m_stall); e.hc = 16'(m_hold); e.er = m_err;
        sb.push_back(e);
    endtask

    // Monitor: compare every presented cycle against the queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            automatic exp_t e = sb.pop_front();
            chk("pc_we", pc_we, e.pc);
            chk("if_id_we", if_id_we, e.ifid);
            chk("pipe_we", pipe_we, e.pipe);
            chk("bubble", id_exe_bubble, e.bub);
            chk("fwda", fwda, e.fa);
            chk("fwdb", fwdb, e.fb);
            chk("state", state, e.st);
            chk("stall_cnt", stall_cnt, e.sc);
            chk("hold_cnt", hold_cnt, e.hc);
            chk("err", err, e.er);
        end
    end

    in_t nop_c, nop, nop_h;

    initial begin
        model_reset();
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        nop_c = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        nop   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        nop_h = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        step(nop_c); #1;
        chk("rst_pc_we", pc_we, 1); chk("rst_state", state, 0);
        chk("rst_fwda", fwda, 0); chk("rst_stall_cnt", stall_cnt, 0);

        // Load r5 then add r6=r5+r7
        step(mk(1, 0, 0, 0, 0, 5, 1, 1, 1, 0));
        step(mk(1, 5, 7, 1, 1, 6, 1, 0, 1, 0)); #1;
        chk("lu_pc_we", pc_we, 0); chk("lu_bubble", id_exe_bubble, 1);
        chk("lu_pipe_we", pipe_we, 1);
        step(mk(1, 5, 7, 1, 1, 6, 1, 0, 1, 0)); #1;
        chk("lu_stall_cnt", stall_cnt, 1); chk("lu_fwda", fwda, 3);
        chk("lu_fwdb", fwdb, 0); chk("lu_pc_we_after", pc_we, 1);

        // add r3 ; sub r4,r3,r3 ; next reader of r3
        step(nop_c);
        step(mk(1, 1, 2, 1, 1, 3, 1, 0, 1, 0));
        step(mk(1, 3, 3, 1, 1, 4, 1, 0, 1, 0)); #1;
        chk("exe_fwda", fwda, 1); chk("exe_fwdb", fwdb, 1); chk("exe_pc_we", pc_we, 1);
        step(mk(1, 3, 3, 1, 1, 8, 1, 0, 1, 0)); #1;
        chk("mem_fwda", fwda, 2); chk("mem_fwdb", fwdb, 2);

        // Load to r0 then r0 reader
        step(nop_c);
        step(mk(1, 0, 0, 0, 0, 0, 1, 1, 1, 0));
        step(mk(1, 0, 0, 1, 1, 9, 1, 0, 1, 0)); #1;
        chk("r0_fwda", fwda, 0); chk("r0_pc_we", pc_we, 1);

        // Memory hold for 3 cycles during a load-use hazard
        step(nop_c);
        step(mk(1, 0, 0, 0, 0, 5, 1, 1, 1, 0));
        for (int i = 0; i < 3; i++) begin
            step(mk(1, 5, 7, 1, 1, 6, 1, 0, 0, 0)); #1;
            chk("hold_pc_we", pc_we, 0); chk("hold_bubble", id_exe_bubble, 0);
            chk("hold_pipe_we", pipe_we, 0);
        end
        step(mk(1, 5, 7, 1, 1, 6, 1, 0, 1, 0)); #1;
        chk("hold_state", state, 2); chk("hold_cnt3", hold_cnt, 3);
        chk("hold_then_bubble", id_exe_bubble, 1);
        step(mk(1, 5, 7, 1, 1, 6, 1, 0, 1, 0)); #1;
        chk("hold_then_stall_state", state, 1); chk("hold_stall_cnt", stall_cnt, 1);
        chk("hold_stall_pc_we", pc_we, 1);
        step(nop); #1;
        chk("hold_single_stall", stall_cnt, 1);

        // Memory timeout
        step(nop_c);
        for (int i = 0; i < 16; i++) begin
            step(nop_h);
            if (i == 15) begin
                #1; chk("to_err_15", err, 0);
            end
        end
        step(nop); #1;
        chk("to_err_16", err, 1); chk("to_hold_cnt", hold_cnt, 16);
        step(nop); #1;
        chk("to_err_sticky", err, 1);
        step(nop_c); #1;
        chk("to_err_clr", err, 0);

        // clr pulsed during HOLD
        step(nop);
        for (int i = 0; i < 3; i++) step(nop_h);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); #1;
        chk("clrh_pc_we", pc_we, 1); chk("clrh_pipe_we", pipe_we, 1);
        chk("clrh_hold_cnt", hold_cnt, 0); chk("clrh_state", state, 0);
        step(mk(1, 0, 0, 0, 0, 9, 1, 0, 1, 0));
        step(mk(1, 9, 0, 1, 0, 10, 1, 0, 1, 0)); #1;
        chk("clrh_shift_fwda", fwda, 1); chk("clrh_run_state", state, 0);

        // Random traffic over a small register set to provoke hazards
        for (int i = 0; i < 800; i++) begin
            step(mk($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 6) != 0, $urandom_range(0, 99) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
